// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
//   op_e    : 3-bit function select, one N-input reduction per code.
//   state_e : sweep controller states.
package truth_table_sweeper_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_MSB  = 3'd6,
    OP_NMSB = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Request/result bundle of the truth-table sweeper.
//   start     : request a sweep (sampled only while idle)
//   op        : function select, latched on an accepted start
//   ref_table : expected truth table, latched on an accepted start
//   busy      : high while minterms are being evaluated
//   done      : one-cycle completion pulse
//   m         : minterm currently being evaluated
//   tbl       : assembled truth table, bit k = f(minterm k)
//   ones      : number of set bits in tbl
//   match     : tbl equals the latched reference (valid after done)
// master drives the request side, slave is the sweeper.
interface truth_table_sweeper_if #(
  parameter int N = 2
);
  localparam int T = 2**N;

  logic         start;
  logic [2:0]   op;
  logic [T-1:0] ref_table;
  logic         busy;
  logic         done;
  logic [N-1:0] m;
  logic [T-1:0] tbl;
  logic [N:0]   ones;
  logic         match;

  modport master (
    output start, op, ref_table,
    input  busy, done, m, tbl, ones, match
  );

  modport slave (
    input  start, op, ref_table,
    output busy, done, m, tbl, ones, match
  );

endinterface

// File: rtl/truth_table_sweeper_logic_fn.sv
// Combinational N-input reduction selected by op.
//   op : function select (op_e encoding)
//   m  : N-bit input combination
//   f  : function value for m
module logic_fn
  import truth_table_sweeper_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] m,
  output logic         f
);

  // NOTE: always_comb uses blocking '=' and assigns every output a default
  // first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    f = 1'b0;
    case (op_e'(op))
      OP_AND:  f = &m;
      OP_OR:   f = |m;
      OP_NAND: f = ~&m;
      OP_NOR:  f = ~|m;
      OP_XOR:  f = ^m;
      OP_XNOR: f = ~^m;
      OP_MSB:  f = m[N-1];
      OP_NMSB: f = ~m[N-1];
      default: f = 1'b0;
    endcase
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweep engine: evaluates the selected reduction for every
// minterm 0..2^N-1, one per clock, builds the table, counts the true
// minterms and compares the table with a caller-supplied reference.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of truth_table_sweeper_if (start/op/ref_table in,
//           busy/done/m/tbl/ones/match out)
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_sweeper_if.slave  bus
);

  localparam int T = 2**N;

  state_e       state_q, state_d;
  logic [2:0]   op_q,    op_d;
  logic [T-1:0] ref_q,   ref_d;
  logic [T-1:0] tbl_q,   tbl_d;
  logic [N-1:0] m_q,     m_d;
  logic [N:0]   ones_q,  ones_d;
  logic         busy_q,  busy_d;
  logic         done_q,  done_d;
  logic         match_q, match_d;
  logic         f;

  // Evaluates the latched function at the current minterm.
  logic_fn #(.N(N)) u_logic_fn (
    .op (op_q),
    .m  (m_q),
    .f  (f)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ref_d   = ref_q;
    tbl_d   = tbl_q;
    m_d     = m_q;
    ones_d  = ones_q;
    match_d = match_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          ref_d   = bus.ref_table;
          tbl_d   = '0;
          m_d     = '0;
          ones_d  = '0;
          match_d = 1'b0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        tbl_d[m_q] = f;
        ones_d     = ones_q + (N+1)'(f);
        // Hold m on the last minterm so it never wraps back to 0.
        if (m_q == N'(T-1)) begin
          state_d = DONE;
        end else begin
          m_d = m_q + N'(1);
        end
      end
      DONE: begin
        // tbl_q is complete here: the last bit was written on entry to DONE.
        match_d = (tbl_q == ref_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d == SWEEP);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      ref_q   <= '0;
      tbl_q   <= '0;
      m_q     <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ref_q   <= ref_d;
      tbl_q   <= tbl_d;
      m_q     <= m_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.m     = m_q;
  assign bus.tbl   = tbl_q;
  assign bus.ones  = ones_q;
  assign bus.match = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper at N=2, 3 and 4. Expected
// tables come from a popcount-based model and are queued when a sweep is
// launched, then popped and compared when the sweeper reports done.
module tb_truth_table_sweeper;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Shared request drivers; sel picks which instance receives start and
  // which instance's outputs appear on the *_s observation signals.
  int          sel       = 2;
  logic        start_drv = 1'b0;
  logic [2:0]  op_drv    = '0;
  logic [15:0] ref_drv   = '0;

  truth_table_sweeper_if #(.N(2)) if2 ();
  truth_table_sweeper_if #(.N(3)) if3 ();
  truth_table_sweeper_if #(.N(4)) if4 ();

  assign if2.start     = start_drv && (sel == 2);
  assign if2.op        = op_drv;
  assign if2.ref_table = ref_drv[3:0];
  assign if3.start     = start_drv && (sel == 3);
  assign if3.op        = op_drv;
  assign if3.ref_table = ref_drv[7:0];
  assign if4.start     = start_drv && (sel == 4);
  assign if4.op        = op_drv;
  assign if4.ref_table = ref_drv;

  truth_table_sweeper #(.N(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  truth_table_sweeper #(.N(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
  truth_table_sweeper #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  logic        busy_s, done_s, match_s;
  logic [3:0]  m_s;
  logic [15:0] tbl_s;
  logic [4:0]  ones_s;

  always_comb begin
    busy_s = 1'b0; done_s = 1'b0; match_s = 1'b0;
    m_s = '0; tbl_s = '0; ones_s = '0;
    case (sel)
      2: begin
        busy_s = if2.busy; done_s = if2.done; match_s = if2.match;
        m_s = 4'(if2.m); tbl_s = 16'(if2.tbl); ones_s = 5'(if2.ones);
      end
      3: begin
        busy_s = if3.busy; done_s = if3.done; match_s = if3.match;
        m_s = 4'(if3.m); tbl_s = 16'(if3.tbl); ones_s = 5'(if3.ones);
      end
      default: begin
        busy_s = if4.busy; done_s = if4.done; match_s = if4.match;
        m_s = if4.m; tbl_s = if4.tbl; ones_s = if4.ones;
      end
    endcase
  end

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  ones;
    logic        match;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input int n, input logic [2:0] op, input logic [15:0] rf);
    exp_t        e;
    int          t;
    int          pop;
    int          msb;
    bit          fv;
    logic [16:0] mask;
    t      = 1 << n;
    e.tbl  = '0;
    e.ones = '0;
    for (int k = 0; k < t; k++) begin
      pop = 0;
      for (int b = 0; b < n; b++) pop += (k >> b) & 1;
      msb = (k >> (n - 1)) & 1;
      case (op)
        3'd0:    fv = (pop == n);
        3'd1:    fv = (pop != 0);
        3'd2:    fv = (pop != n);
        3'd3:    fv = (pop == 0);
        3'd4:    fv = (pop % 2) == 1;
        3'd5:    fv = (pop % 2) == 0;
        3'd6:    fv = (msb == 1);
        default: fv = (msb == 0);
      endcase
      e.tbl[k] = fv;
      e.ones   = e.ones + 5'(fv);
    end
    mask    = (17'd1 << t) - 17'd1;
    e.match = (e.tbl == (rf & mask[15:0]));
    return e;
  endfunction

  // Caller is at a negedge; start is sampled by the next rising edge.
  task automatic start_sweep(input int n, input logic [2:0] op, input logic [15:0] rf);
    sel       = n;
    op_drv    = op;
    ref_drv   = rf;
    start_drv = 1'b1;
    sb.push_back(model(n, op, rf));
  endtask

  // Follows a launched sweep up to its done cycle. Cycle i is the i-th
  // cycle after the start edge. Optionally re-pulses start with a different
  // op at cycle pulse_at to show it is ignored.
  task automatic observe(input string name, input int n, input int pulse_at, output int done_cyc);
    int   t;
    int   busy_cnt;
    int   done_at;
    int   i;
    bit   overlap;
    bit   m_bad;
    exp_t e;
    t = 1 << n; busy_cnt = 0; done_at = 0; i = 0;
    overlap = 1'b0; m_bad = 1'b0; done_cyc = 0;
    while (done_at == 0 && i < 60) begin
      @(negedge clk);
      i++;
      if (i == 1) start_drv = 1'b0;
      if (pulse_at != 0 && i == pulse_at) begin
        start_drv = 1'b1; op_drv = 3'd1; ref_drv = '0;
      end
      if (pulse_at != 0 && i == pulse_at + 1) start_drv = 1'b0;
      if (busy_s && done_s) overlap = 1'b1;
      if (busy_s) begin
        busy_cnt++;
        if (m_s !== 4'(i - 1)) m_bad = 1'b1;
      end
      if (done_s) begin
        done_at  = i;
        done_cyc = cyc;
      end
    end
    checks++;
    if (done_at !== t + 1) begin
      errors++;
      $display("FAIL %s done_latency: got %0d expected %0d", name, done_at, t + 1);
    end
    checks++;
    if (busy_cnt !== t) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, t);
    end
    checks++;
    if (overlap !== 1'b0 || m_bad !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_done_overlap/m_sequence: got %0b/%0b expected 0/0", name, overlap, m_bad);
    end
    if (done_at != 0) begin
      checks++;
      if (m_s !== 4'(t - 1)) begin
        errors++;
        $display("FAIL %s m_hold: got %0d expected %0d", name, m_s, t - 1);
      end
      checks++;
      if (match_s !== 1'b0) begin
        errors++;
        $display("FAIL %s match_cleared_in_done: got %0b expected 0", name, match_s);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard: got empty queue expected an entry", name);
      end else begin
        e = sb[0];
        if (tbl_s !== e.tbl || ones_s !== e.ones) begin
          errors++;
          $display("FAIL %s table/ones: got %h/%0d expected %h/%0d", name, tbl_s, ones_s, e.tbl, e.ones);
        end
      end
    end
  endtask

  // The registered match is visible in the cycle after done.
  task automatic check_match(input string name);
    exp_t e;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s match: got empty queue expected an entry", name);
    end else begin
      e = sb.pop_front();
      if (match_s !== e.match || busy_s !== 1'b0 || done_s !== 1'b0) begin
        errors++;
        $display("FAIL %s match/busy/done: got %0b/%0b/%0b expected %0b/0/0",
                 name, match_s, busy_s, done_s, e.match);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int n = 2; n <= 4; n++) begin
      sel = n;
      #1;
      checks++;
      if ({busy_s, done_s, match_s, m_s, tbl_s, ones_s} !== '0) begin
        errors++;
        $display("FAIL reset_values_n%0d: got busy=%0b done=%0b match=%0b m=%0d tbl=%h ones=%0d expected all 0",
                 n, busy_s, done_s, match_s, m_s, tbl_s, ones_s);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_nor();
    int d;
    @(negedge clk);
    start_sweep(2, 3'd3, 16'h0001);
    observe("nor_n2", 2, 0, d);
    check_match("nor_n2");
  endtask

  task automatic test_xor();
    int d;
    @(negedge clk);
    start_sweep(2, 3'd4, 16'h0009);
    observe("xor_n2", 2, 0, d);
    check_match("xor_n2");
  endtask

  task automatic test_all_ops();
    int          d;
    logic [15:0] rf;
    exp_t        e;
    for (int op = 0; op < 8; op++) begin
      e  = model(3, 3'(op), 16'h0);
      rf = (op % 2 == 0) ? e.tbl : 16'($urandom_range(0, 255));
      @(negedge clk);
      start_sweep(3, 3'(op), rf);
      observe($sformatf("op%0d_n3", op), 3, 0, d);
      check_match($sformatf("op%0d_n3", op));
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    @(negedge clk);
    start_sweep(3, 3'd0, 16'h0080);
    observe("b2b_and_n3", 3, 0, d1);
    check_match("b2b_and_n3");
    // Same negedge as the match check: first IDLE cycle after DONE.
    start_sweep(3, 3'd1, 16'h00FE);
    observe("b2b_or_n3", 3, 0, d2);
    check_match("b2b_or_n3");
    checks++;
    if (d2 - d1 !== 10) begin
      errors++;
      $display("FAIL b2b_period: got %0d expected 10", d2 - d1);
    end
  endtask

  task automatic test_ignore_start();
    int d;
    int extra;
    @(negedge clk);
    start_sweep(2, 3'd6, 16'h000C);
    observe("ignore_start_n2", 2, 2, d);
    check_match("ignore_start_n2");
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_s || busy_s) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_start_no_restart: got %0d busy/done cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int d;
    int done_cnt;
    @(negedge clk);
    start_sweep(4, 3'd2, 16'h7FFF);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) start_drv = 1'b0;
    end
    checks++;
    if (busy_s !== 1'b1) begin
      errors++;
      $display("FAIL midreset_precondition_busy: got %0b expected 1", busy_s);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_s, done_s, match_s, m_s, tbl_s, ones_s} !== '0) begin
      errors++;
      $display("FAIL midreset_values: got busy=%0b done=%0b match=%0b m=%0d tbl=%h ones=%0d expected all 0",
               busy_s, done_s, match_s, m_s, tbl_s, ones_s);
    end
    sb.delete();
    reset = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_s || busy_s) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d busy/done cycles expected 0", done_cnt);
    end
    start_sweep(4, 3'd2, 16'h7FFF);
    observe("nand_n4", 4, 0, d);
    check_match("nand_n4");
  endtask

  initial begin
    test_reset();
    test_nor();
    test_xor();
    test_all_ops();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
